// File: rtl/clkgen_frac.sv
// clkgen_frac: one-hot strobe ring, half-rate f0/f1 pair and NCH phase-accumulator clocks.
// Optional CLKGEN_RESYNC_EN adds a resync input that realigns ring and accumulators.

module clkgen_frac_ch #(
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             resync_i,
    input  logic [ACC_W-1:0] inc_i,
    input  logic             inc_ld_i,
    output logic             fclk_o,
    output logic             fstb_o,
    output logic             busy_o
);
    logic [ACC_W-1:0] acc_q, acc_d, act_q, act_d, pend_q, pend_d;
    logic             busy_q, busy_d, fstb_q, fstb_d;
    logic [ACC_W:0]   sum;
    logic             wrap;

    always_comb begin
        sum    = {1'b0, acc_q} + {1'b0, act_q};
        wrap   = sum[ACC_W];
        acc_d  = sum[ACC_W-1:0];
        act_d  = act_q;
        pend_d = pend_q;
        busy_d = busy_q;
        fstb_d = ~acc_q[ACC_W-1] & acc_d[ACC_W-1];
        if (resync_i) begin
            acc_d  = '0;
            fstb_d = 1'b0;
            busy_d = 1'b0;
            act_d  = inc_ld_i ? inc_i : (busy_q ? pend_q : act_q);
        end else if (inc_ld_i) begin
            // A load landing on the wrap goes straight to the active increment.
            pend_d = inc_i;
            if (wrap) begin
                act_d  = inc_i;
                busy_d = 1'b0;
            end else begin
                busy_d = 1'b1;
            end
        end else if (busy_q && (wrap || act_q == '0)) begin
            // Switch only at the falling edge (or when stopped) so no runt phase appears.
            act_d  = pend_q;
            busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            act_q  <= '0;
            pend_q <= '0;
            busy_q <= 1'b0;
            fstb_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            act_q  <= act_d;
            pend_q <= pend_d;
            busy_q <= busy_d;
            fstb_q <= fstb_d;
        end
    end

    assign fclk_o = acc_q[ACC_W-1];
    assign fstb_o = fstb_q;
    assign busy_o = busy_q;
endmodule

module clkgen_frac #(
    parameter int PHASES = 4,
    parameter int ACC_W  = 16,
    parameter int NCH    = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ph_en,
`ifdef CLKGEN_RESYNC_EN
    input  logic                 resync,
`endif
    output logic [PHASES-1:0]    c,
    output logic                 f0,
    output logic                 f1,
    input  logic [NCH*ACC_W-1:0] inc,
    input  logic [NCH-1:0]       inc_ld,
    output logic [NCH-1:0]       fclk,
    output logic [NCH-1:0]       fstb,
    output logic [NCH-1:0]       busy
);
    logic [PHASES-1:0] c_q, c_d;
    logic              f0_q, f0_d;
    logic              rsy;

`ifdef CLKGEN_RESYNC_EN
    assign rsy = resync;
`else
    assign rsy = 1'b0;
`endif

    always_comb begin
        c_d  = c_q;
        f0_d = f0_q;
        if (rsy) begin
            c_d    = '0;
            c_d[0] = 1'b1;
            f0_d   = 1'b1;
        end else if (ph_en) begin
            c_d  = {c_q[PHASES-2:0], c_q[PHASES-1]};
            f0_d = ~f0_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_q  <= {{(PHASES-1){1'b0}}, 1'b1};
            f0_q <= 1'b1;
        end else begin
            c_q  <= c_d;
            f0_q <= f0_d;
        end
    end

    assign c  = c_q;
    assign f0 = f0_q;
    assign f1 = ~f0_q;

    for (genvar n = 0; n < NCH; n++) begin : g_ch
        clkgen_frac_ch #(.ACC_W(ACC_W)) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .resync_i (rsy),
            .inc_i    (inc[n*ACC_W +: ACC_W]),
            .inc_ld_i (inc_ld[n]),
            .fclk_o   (fclk[n]),
            .fstb_o   (fstb[n]),
            .busy_o   (busy[n])
        );
    end
endmodule

// File: doc/clkgen_frac.md
Name: clkgen_frac

Overview:
Parametrised master-clock strobe and fractional-clock generator driven from the 28 MHz system clock.
- Produces an N-phase one-hot strobe ring and a half-rate toggle pair for clocked parts.
- Provides NCH independent phase-accumulator clocks for sound chips and peripherals, e.g. AY at 1.75, 1.7734 or 3.5469 MHz.
- Per-channel increments reload at runtime without runt pulses.
- Successor to the fixed 4-phase / skip-counter generator.

Parameters:
PHASES, 4, length of the one-hot strobe ring; legal range 2..16.
ACC_W, 16, phase-accumulator width in bits; legal range 8..24.
NCH, 2, number of fractional clock channels; legal range 1..8.

Ports:
clk  in  1  master clock, 28 MHz.
rst_n  in  1  asynchronous active-low reset.
ph_en  in  1  clock enable for the strobe ring and the f pair; fractional channels ignore it.
c  out  PHASES  one-hot phase strobes; c[k] is high during cycle k of the ring.
f0, f1  out  1  half-rate toggles; f1 is always the complement of f0.
inc  in  NCH*ACC_W  per-channel increment; channel n uses bits [n*ACC_W +: ACC_W].
inc_ld  in  NCH  one-cycle load request for the channel increment.
fclk  out  NCH  fractional clock, equal to the accumulator MSB.
fstb  out  NCH  one-cycle pulse in the first cycle that fclk reads 1.
busy  out  NCH  a loaded increment is pending and not yet applied.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - c = 1 (bit 0 set), f0 = 1, f1 = 0.
  - All accumulators, active increments and pending increments = 0.
  - fclk = 0, fstb = 0, busy = 0.
- Strobe ring:
  - On each clk with ph_en = 1, c rotates left: c <= {c[PHASES-2:0], c[PHASES-1]}, and f0/f1 toggle.
  - With ph_en = 0, c and f0/f1 hold.
  - Exactly one bit of c is set at all times.
- Fractional channel n:
  - Registers: acc_n (ACC_W bits), act_n (active increment), pend_n (pending increment).
  - Every clk: acc_n <= acc_n + act_n, modulo 2^ACC_W; the carry is discarded.
  - fclk[n] = acc_n[ACC_W-1]. Average frequency = f_clk * act_n / 2^ACC_W.
  - act_n > 2^(ACC_W-1) aliases the output; that is legal and not checked.
  - fstb[n] is registered: high in the cycle acc_n MSB transitions 0 -> 1, so it coincides with the fclk rising edge.
- Increment update:
  - inc_ld[n] = 1 captures inc slice into pend_n and sets busy[n] in the next cycle.
  - Apply point: pend_n is copied to act_n, and busy[n] clears, in the cycle the addition wraps (carry out = 1). The wrap is the fclk falling edge, so no runt high or low phase is produced.
  - act_n = 0 (channel stopped): the pending value applies on the cycle after the load.
  - Writing 0 stops the channel at its next wrap. fclk then holds 0 and acc_n holds its post-wrap value.
  - inc_ld while busy: pend_n is overwritten and busy stays 1. Only the last value loaded before the wrap applies.
  - inc_ld in the same cycle as a wrap: the new inc value goes straight to act_n, busy = 0, and the older pending value is discarded.
- Channels are fully independent, with no cross-channel timing relation.
- Reset mid-operation: immediate return to reset state; pending loads are lost.

Optional Feature:
CLKGEN_RESYNC_EN
- Defined: adds input port resync (1 bit).
  - resync = 1 for one clk returns c to bit 0, f0 to 1 and f1 to 0, regardless of ph_en.
  - It also clears every acc_n to 0 and applies any pending increments at once, clearing busy.
  - fstb does not fire for the clearing.
  - Used to phase-align sound clocks to the ring after a mode switch.
- Not defined: no resync port. The ring and accumulators free-run from reset only.

Test Plan:
- Settings PHASES=4, ph_en=1 from reset → c = 0001, 0010, 0100, 1000, 0001…; f0 = 1,0,1,0…. Then drop ph_en for 3 clk → c and f frozen for 3 clk.
- Settings ACC_W=16, load inc = 0x1000 on ch0 after reset → act applies 1 clk after the load. fclk period is exactly 16 clk with 8 high / 8 low; fstb fires once per 16 clk.
- Load inc = 4151 (0x1037, 1.7734 MHz at 28 MHz) → over 65536 clk, fstb count = 4151 exactly and acc returns to its start value.
- Channel running at 0x1000, load 0x2000 mid-high-phase → busy = 1 until the next wrap. No fclk high or low phase shorter than 8 clk before the switch, then period 8.
- Loads 0x0800 then 0x4000 on consecutive cycles while busy, and a load coincident with a wrap → only 0x4000 applies at the wrap. A coincident load applies immediately with busy = 0.
- rst_n asserted mid-count on 2 channels → all outputs go to reset values without waiting for clk. With CLKGEN_RESYNC_EN, a resync pulse gives c = 0001 and fclk = 0 on all channels in the next cycle, with no fstb pulse.
